// File: rtl/seq_accumulator_4b.sv
// rtl/seq_accumulator_4b.sv - burst accumulator: sums COUNT_MAX streamed operands, counts carries, pulses done
// Optional macro SATURATE_EN: clamp acc to all-ones on carry instead of wrapping.
module seq_accumulator_4b #(
    parameter int WIDTH     = 4,
    parameter int COUNT_MAX = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] acc,
    output logic [3:0]       carry_cnt,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(COUNT_MAX + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(COUNT_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] acc_nx;
    logic [3:0]       carry_cnt_nx;
    logic [BW-1:0]    beat;
    logic [BW-1:0]    beat_nx;
    logic [WIDTH:0]   sum;

    // One extra bit so the adder's carry-out is visible.
    assign sum = {1'b0, acc} + {1'b0, in_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            carry_cnt <= '0;
            beat      <= '0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            carry_cnt <= carry_cnt_nx;
            beat      <= beat_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        carry_cnt_nx = carry_cnt;
        beat_nx      = beat;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    acc_nx       = '0;
                    carry_cnt_nx = '0;
                    beat_nx      = '0;
                    state_nx     = ACCUM;
                end
            end

            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
`ifdef SATURATE_EN
                    acc_nx = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                    acc_nx = sum[WIDTH-1:0];
`endif
                    if (sum[WIDTH] && (carry_cnt != 4'hF)) begin
                        carry_cnt_nx = carry_cnt + 4'd1;
                    end
                    beat_nx = beat + BW'(1);
                    if (beat_nx == BEAT_LAST) begin
                        state_nx = DONE;
                    end
                end
            end

            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_accumulator_4b.sv
// tb/tb_seq_accumulator_4b.sv - directed and model-checked bench for seq_accumulator_4b
module tb_seq_accumulator_4b;

    logic       clk = 1'b0;
    logic       reset, start, in_valid;
    logic [3:0] in_data;
    logic       in_ready, busy, done;
    logic [3:0] acc, carry_cnt;

    logic       b_reset, b_start, b_in_valid;
    logic [3:0] b_in_data;
    logic       b_in_ready, b_busy, b_done;
    logic [3:0] b_acc, b_carry_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_accumulator_4b #(.WIDTH(4), .COUNT_MAX(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .acc(acc), .carry_cnt(carry_cnt), .busy(busy), .done(done)
    );

    seq_accumulator_4b #(.WIDTH(4), .COUNT_MAX(20)) u_dut20 (
        .clk(clk), .reset(b_reset), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .acc(b_acc), .carry_cnt(b_carry_cnt), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [3:0] d, input int gaps);
        repeat (gaps) begin
            in_valid = 1'b0;
            in_data  = 4'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    logic [3:0] ops4 [8] = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd2, 4'd4, 4'd6, 4'd8};
    logic [3:0] macc, mcc, d;
    logic [4:0] s;

    initial begin
        reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 4'hF;
        b_reset = 1'b1; b_start = 1'b0; b_in_valid = 1'b0; b_in_data = 4'h0;
        tick(); tick();
        chk("rst_acc", acc, 0);
        chk("rst_carry", carry_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; b_reset = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // 8 x 1, no gaps
        do_start();
        chk("t2_in_ready", in_ready, 1);
        chk("t2_busy", busy, 1);
        chk("t2_acc0", acc, 0);
        feed(4'h1, 0);
        chk("t2_latency", acc, 1);
        for (int i = 1; i < 8; i++) begin
            chk("t2_nodone", done, 0);
            feed(4'h1, 0);
        end
        chk("t2_done", done, 1);
        chk("t2_done_ready", in_ready, 0);
        chk("t2_acc", acc, 8);
        chk("t2_carry", carry_cnt, 0);
        in_valid = 1'b1; in_data = 4'hF;
        tick();
        in_valid = 1'b0;
        chk("t2_done_pulse", done, 0);
        chk("t2_idle_busy", busy, 0);
        chk("t2_hold_acc", acc, 8);

        // 8 x F
        do_start();
        for (int i = 0; i < 8; i++) feed(4'hF, 0);
        chk("t3_done", done, 1);
`ifdef SATURATE_EN
        chk("t3_acc", acc, 4'hF);
`else
        chk("t3_acc", acc, 4'h8);
`endif
        chk("t3_carry", carry_cnt, 7);
        tick();

        // gapped operands, start pulsed mid-burst
        do_start();
        for (int i = 0; i < 8; i++) begin
            if (i == 4) start = 1'b1;
            feed(ops4[i], 1);
            start = 1'b0;
        end
        chk("t4_done", done, 1);
`ifdef SATURATE_EN
        chk("t4_acc", acc, 4'hF);
        chk("t4_carry", carry_cnt, 5);
`else
        chk("t4_acc", acc, 4'hC);
        chk("t4_carry", carry_cnt, 2);
`endif
        tick();
        tick();
        chk("t4_no_restart", busy, 0);

        // reset after 4th accept
        do_start();
        for (int i = 0; i < 4; i++) feed(4'hF, 0);
`ifdef SATURATE_EN
        chk("t5_mid_acc", acc, 4'hF);
`else
        chk("t5_mid_acc", acc, 4'hC);
`endif
        chk("t5_mid_carry", carry_cnt, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_acc", acc, 0);
        chk("t5_rst_carry", carry_cnt, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", in_ready, 0);
        tick();
        chk("t5_no_done", done, 0);
        do_start();
        for (int i = 0; i < 8; i++) feed(4'h2, 0);
        chk("t5_done", done, 1);
`ifdef SATURATE_EN
        chk("t5_acc", acc, 4'hF);
`else
        chk("t5_acc", acc, 4'h0);
`endif
        chk("t5_carry", carry_cnt, 1);
        tick();

        // COUNT_MAX=20, all F: carry count saturates at 15
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_in_valid = 1'b1; b_in_data = 4'hF;
        repeat (20) tick();
        b_in_valid = 1'b0;
        chk("t6s_done", b_done, 1);
        chk("t6s_carry", b_carry_cnt, 15);
`ifdef SATURATE_EN
        chk("t6s_acc", b_acc, 4'hF);
`else
        chk("t6s_acc", b_acc, 4'hC);
`endif
        tick();
        chk("t6s_idle", b_busy, 0);

        // random bursts against a reference model
        for (int b = 0; b < 200; b++) begin
            do_start();
            macc = 4'h0; mcc = 4'h0;
            for (int i = 0; i < 8; i++) begin
                d = 4'($urandom);
                s = {1'b0, macc} + {1'b0, d};
`ifdef SATURATE_EN
                macc = s[4] ? 4'hF : s[3:0];
`else
                macc = s[3:0];
`endif
                if (s[4] && mcc != 4'hF) mcc = mcc + 4'd1;
                feed(d, $urandom_range(0, 2));
            end
            chk("t6_done", done, 1);
            chk("t6_acc", acc, macc);
            chk("t6_carry", carry_cnt, mcc);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
